// File: rtl/alu_wb_if.sv
// Writeback-stage bus: ALU result/control in, architectural state and RAM write port out.
interface alu_wb_if #(parameter int RAM_AW = 8);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        a;
  logic [7:0]        b;
  logic [7:0]        alu_o;
  logic              alu_cy;
  logic [7:0]        shift_o;
  logic [2:0]        method;
  logic              sel_shift;
  logic              upd_flags;
  logic [1:0]        dest;
  logic [RAM_AW-1:0] dest_addr;
  logic              psw_we;
  logic [7:0]        psw_wdata;
  logic [7:0]        acc;
  logic [7:0]        b_reg;
  logic [7:0]        psw;
  logic              cy_fb;
  logic              ram_valid;
  logic              ram_ready;
  logic [RAM_AW-1:0] ram_addr;
  logic [7:0]        ram_data;

  modport master (
    output in_valid, a, b, alu_o, alu_cy, shift_o, method, sel_shift, upd_flags,
           dest, dest_addr, psw_we, psw_wdata, ram_ready,
    input  in_ready, acc, b_reg, psw, cy_fb, ram_valid, ram_addr, ram_data
  );

  modport slave (
    input  in_valid, a, b, alu_o, alu_cy, shift_o, method, sel_shift, upd_flags,
           dest, dest_addr, psw_we, psw_wdata, ram_ready,
    output in_ready, acc, b_reg, psw, cy_fb, ram_valid, ram_addr, ram_data
  );
endinterface

// File: rtl/alu_wb.sv
// 8051 ALU writeback: PSW flag derivation, ACC/B/PSW ownership and a one-entry
// holding register that absorbs internal-RAM write back-pressure.
module alu_wb #(
  parameter int RAM_AW = 8
) (
  input  logic    clk,
  input  logic    rst,
  alu_wb_if.slave wb
);
  typedef enum logic {IDLE, HOLD} state_e;

  state_e            state_q;
  logic [7:0]        acc_q, b_q, ram_data_q;
  logic [7:1]        psw_q;
  logic [RAM_AW-1:0] ram_addr_q;
  logic              ram_valid_q;

  logic [7:0] res;
  logic       accept, is_arith, flag_upd, to_ram;
  logic       ac_d, ov_d;
  logic [4:0] nib_sum, nib_rhs;

  assign res       = wb.sel_shift ? wb.shift_o : wb.alu_o;
  assign wb.in_ready = (state_q == IDLE) | wb.ram_ready;
  assign accept    = wb.in_valid & wb.in_ready;
  assign to_ram    = accept & (wb.dest == 2'd2);
  assign is_arith  = (wb.method == 3'd0) | (wb.method == 3'd1);
  assign flag_upd  = accept & wb.upd_flags & is_arith;

  // Half-carry/borrow uses the same carry-in the ALU saw this cycle.
  assign nib_sum = {1'b0, wb.a[3:0]} + {1'b0, wb.b[3:0]} + {4'd0, psw_q[7]};
  assign nib_rhs = {1'b0, wb.b[3:0]} + {4'd0, psw_q[7]};

  always_comb begin
    if (wb.method == 3'd0) begin
      ac_d = nib_sum[4];
      ov_d = (wb.a[7] == wb.b[7]) & (res[7] != wb.a[7]);
    end else begin
      ac_d = ({1'b0, wb.a[3:0]} < nib_rhs);
      ov_d = (wb.a[7] != wb.b[7]) & (res[7] != wb.a[7]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      acc_q       <= '0;
      b_q         <= '0;
      psw_q       <= '0;
      ram_valid_q <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
    end else begin
      if (accept && wb.dest == 2'd1) acc_q <= res;
      if (accept && wb.dest == 2'd3) b_q   <= res;
      if (flag_upd) begin
        psw_q[7] <= wb.alu_cy;
        psw_q[6] <= ac_d;
        psw_q[2] <= ov_d;
      end
      // Direct SFR write is last so it overrides any same-edge flag update.
      if (wb.psw_we) psw_q <= wb.psw_wdata[7:1];

      case (state_q)
        IDLE: begin
          if (to_ram) begin
            state_q     <= HOLD;
            ram_valid_q <= 1'b1;
            ram_addr_q  <= wb.dest_addr;
            ram_data_q  <= res;
          end
        end
        HOLD: begin
          if (wb.ram_ready) begin
            if (to_ram) begin
              ram_addr_q <= wb.dest_addr;
              ram_data_q <= res;
            end else begin
              state_q     <= IDLE;
              ram_valid_q <= 1'b0;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign wb.acc       = acc_q;
  assign wb.b_reg     = b_q;
  assign wb.psw       = {psw_q, ^acc_q};
  assign wb.cy_fb     = psw_q[7];
  assign wb.ram_valid = ram_valid_q;
  assign wb.ram_addr  = ram_addr_q;
  assign wb.ram_data  = ram_data_q;
endmodule

// File: tb/tb_alu_wb.sv
// Directed + random bench for alu_wb against a queue-based architectural model.
module tb_alu_wb;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_wb_if #(.RAM_AW(8)) bus ();
  alu_wb #(.RAM_AW(8)) dut (.clk(clk), .rst(rst), .wb(bus));

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  m_acc, m_b, m_psw;
  logic [15:0] m_q[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] r, input logic cy, input logic [2:0] m,
                       input logic upd, input logic [1:0] d, input logic [7:0] addr);
    bus.in_valid = v;  bus.a = a;  bus.b = b;  bus.alu_o = r;  bus.alu_cy = cy;
    bus.shift_o = ~r;  bus.sel_shift = 1'b0;   bus.method = m;  bus.upd_flags = upd;
    bus.dest = d;      bus.dest_addr = addr;
  endtask

  task automatic model_edge();
    logic [7:0] np, r;
    logic old_cy, take;
    int an, bn;
    if (rst) begin
      m_acc = 0; m_b = 0; m_psw = 0; m_q.delete();
      return;
    end
    take   = bus.in_valid && (m_q.size() == 0 || bus.ram_ready);
    old_cy = m_psw[7];
    np     = m_psw;
    if (m_q.size() > 0 && bus.ram_ready) void'(m_q.pop_front());
    if (take) begin
      r = bus.sel_shift ? bus.shift_o : bus.alu_o;
      case (bus.dest)
        2'd1: m_acc = r;
        2'd2: m_q.push_back({bus.dest_addr, r});
        2'd3: m_b = r;
        default: ;
      endcase
      if (bus.upd_flags && bus.method < 3'd2) begin
        an = int'(bus.a % 16);
        bn = int'(bus.b % 16);
        np[7] = bus.alu_cy;
        if (bus.method == 3'd0) begin
          np[6] = (an + bn + int'(old_cy)) > 15;
          np[2] = (bus.a[7] == bus.b[7]) && (r[7] != bus.a[7]);
        end else begin
          np[6] = an < (bn + int'(old_cy));
          np[2] = (bus.a[7] != bus.b[7]) && (r[7] != bus.a[7]);
        end
      end
    end
    if (bus.psw_we) np[7:1] = bus.psw_wdata[7:1];
    m_psw = np;
  endtask

  task automatic check_outs();
    chk("acc", bus.acc, m_acc);
    chk("b_reg", bus.b_reg, m_b);
    chk("psw", bus.psw, {m_psw[7:1], ^m_acc});
    chk("cy_fb", bus.cy_fb, m_psw[7]);
    chk("ram_valid", bus.ram_valid, m_q.size() > 0);
    if (m_q.size() > 0) begin
      chk("ram_addr", bus.ram_addr, m_q[0][15:8]);
      chk("ram_data", bus.ram_data, m_q[0][7:0]);
    end
  endtask

  // Inputs are set at the negedge before calling; checks ready, clocks, checks state.
  task automatic cyc();
    #1;
    chk("in_ready", bus.in_ready, (m_q.size() == 0) || bus.ram_ready);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outs();
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    bus.psw_we = 0; bus.psw_wdata = 0; bus.ram_ready = 1;
    m_acc = 8'hAA; m_b = 8'hAA; m_psw = 8'hAA;
    @(negedge clk);
    cyc();
    rst = 1'b0;
    chk("reset_acc", bus.acc, 8'h00);
    chk("reset_in_ready", bus.in_ready, 1'b1);

    // add 7F+01, cy=0
    drive(1, 8'h7F, 8'h01, 8'h80, 0, 3'd0, 1, 2'd1, 0); cyc();
    chk("t1_acc", bus.acc, 8'h80);
    chk("t1_psw", bus.psw, 8'h45);

    // set CY via SFR write, then sub 10-01-1
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); bus.psw_we = 1; bus.psw_wdata = 8'h80; cyc();
    bus.psw_we = 0;
    drive(1, 8'h10, 8'h01, 8'h0E, 0, 3'd1, 1, 2'd1, 0); cyc();
    chk("t2_acc", bus.acc, 8'h0E);
    chk("t2_psw", bus.psw, 8'h41);

    // RAM back-pressure
    bus.ram_ready = 0;
    drive(1, 0, 0, 8'h55, 0, 3'd2, 0, 2'd2, 8'h30); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t3_addr", bus.ram_addr, 8'h30);
      chk("t3_data", bus.ram_data, 8'h55);
      chk("t3_ready", bus.in_ready, 1'b0);
    end
    bus.ram_ready = 1; cyc();
    chk("t3_release", bus.ram_valid, 1'b0);

    // back-to-back RAM writes
    drive(1, 0, 0, 8'hA1, 0, 3'd3, 0, 2'd2, 8'h30); cyc();
    chk("t4_first", bus.ram_addr, 8'h30);
    drive(1, 0, 0, 8'hA2, 0, 3'd3, 0, 2'd2, 8'h31); cyc();
    chk("t4_second_v", bus.ram_valid, 1'b1);
    chk("t4_second_a", bus.ram_addr, 8'h31);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); cyc();

    // psw_we beats flag update
    drive(1, 8'hFF, 8'hFF, 8'hFE, 1, 3'd0, 1, 2'd1, 0);
    bus.psw_we = 1; bus.psw_wdata = 8'h18; cyc();
    bus.psw_we = 0;
    chk("t5_psw", bus.psw, {7'h0C, ^8'hFE});

    // reset while holding
    bus.ram_ready = 0;
    drive(1, 0, 0, 8'h77, 0, 3'd2, 0, 2'd2, 8'h40); cyc();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1; cyc(); rst = 0;
    chk("t6_valid", bus.ram_valid, 1'b0);
    chk("t6_psw", bus.psw, 8'h00);
    chk("t6_ready", bus.in_ready, 1'b1);
    bus.ram_ready = 1;

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, 8'($urandom), 8'($urandom), 8'($urandom),
            1'($urandom), 3'($urandom_range(0, 7)), 1'($urandom),
            2'($urandom), 8'($urandom));
      bus.shift_o   = 8'($urandom);
      bus.sel_shift = 1'($urandom);
      bus.psw_we    = ($urandom_range(0, 7) == 0);
      bus.psw_wdata = 8'($urandom);
      bus.ram_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 63) == 0);
      cyc();
    end
    rst = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
